// File: rtl/proc_zbt_writer.sv
// ZBT bank-1 writer: commits processed pixel pairs during capture frames
// and shares the port with display reads on alternate hcount slots.
module proc_zbt_writer #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int H_TOTAL  = 1344,
  parameter int V_TOTAL  = 806,
  parameter int ZBT_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [35:0] two_proc_pixs,
  input  logic [18:0] proc_pix_addr,
  input  logic [18:0] disp_addr,
  input  logic        capture,
  input  logic        continuous,
  input  logic [35:0] zbt_read_data,
  output logic [18:0] zbt_addr,
  output logic        zbt_we,
  output logic [35:0] zbt_write_data,
  output logic [35:0] disp_pixs,
  output logic        busy,
  output logic        frame_done,
  output logic [18:0] write_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  state_t state;

  logic [ZBT_LAT-1:0] we_pipe;
  logic [35:0]        pix_pipe [ZBT_LAT];
  logic [ZBT_LAT:0]   rd_pipe;

  logic frame_start;
  logic frame_end;
  logic do_write;

  always_comb begin
    frame_start = (hcount == '0) && (vcount == '0);
    frame_end   = (hcount == 11'(H_TOTAL - 1)) &&
                  (vcount == 10'(V_TOTAL - 1));
    do_write    = hcount[0] && (state == CAPTURE) &&
                  (hcount < 11'(H_ACTIVE)) &&
                  (vcount < 10'(V_ACTIVE));
  end

  // Read tags need one extra stage: data lands ZBT_LAT cycles after
  // the registered address, and disp_pixs registers it one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      write_count    <= '0;
      zbt_addr       <= '0;
      zbt_we         <= 1'b0;
      zbt_write_data <= '0;
      disp_pixs      <= '0;
      we_pipe        <= '0;
      rd_pipe        <= '0;
      for (int i = 0; i < ZBT_LAT; i++)
        pix_pipe[i] <= '0;
    end else begin
      zbt_addr    <= hcount[0] ? proc_pix_addr : disp_addr;
      zbt_we      <= do_write;
      we_pipe[0]  <= do_write;
      pix_pipe[0] <= two_proc_pixs;
      rd_pipe[0]  <= ~hcount[0];
      for (int i = 1; i < ZBT_LAT; i++) begin
        we_pipe[i]  <= we_pipe[i-1];
        pix_pipe[i] <= pix_pipe[i-1];
      end
      for (int i = 1; i <= ZBT_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];

      if (we_pipe[ZBT_LAT-1])
        zbt_write_data <= pix_pipe[ZBT_LAT-1];
      if (rd_pipe[ZBT_LAT])
        disp_pixs <= zbt_read_data;

      frame_done <= (state == CAPTURE) && frame_end;

      if ((state != IDLE) && frame_start)
        write_count <= '0;
      else if (zbt_we && (write_count != '1))
        write_count <= write_count + 19'd1;

      unique case (state)
        IDLE: begin
          if (capture) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (frame_start)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (frame_end && !continuous) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_zbt_writer.sv
// Bench for proc_zbt_writer on a shrunken raster; a cycle model plus
// write/read scoreboards check every output each clock.
module tb_proc_zbt_writer;

  localparam int HA  = 8;
  localparam int VA  = 4;
  localparam int HT  = 12;
  localparam int VT  = 6;
  localparam int LAT = 2;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [35:0] two_proc_pixs;
  logic [18:0] proc_pix_addr;
  logic [18:0] disp_addr;
  logic        capture;
  logic        continuous;
  logic [35:0] zbt_read_data;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_write_data;
  logic [35:0] disp_pixs;
  logic        busy;
  logic        frame_done;
  logic [18:0] write_count;

  always #5 clk = ~clk;

  proc_zbt_writer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_TOTAL(HT), .V_TOTAL(VT),
    .ZBT_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hcount(hcount),
    .vcount(vcount),
    .two_proc_pixs(two_proc_pixs),
    .proc_pix_addr(proc_pix_addr),
    .disp_addr(disp_addr),
    .capture(capture),
    .continuous(continuous),
    .zbt_read_data(zbt_read_data),
    .zbt_addr(zbt_addr),
    .zbt_we(zbt_we),
    .zbt_write_data(zbt_write_data),
    .disp_pixs(disp_pixs),
    .busy(busy),
    .frame_done(frame_done),
    .write_count(write_count)
  );

  typedef enum int {M_IDLE, M_ARMED, M_CAP} mst_t;
  typedef struct {
    int          due;
    logic [35:0] val;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int we_seen = 0;
  int fd_seen = 0;

  mst_t        m_st;
  logic        e_we, e_busy, e_fd;
  logic [18:0] e_addr, e_wc;
  logic [35:0] e_wd, e_disp;
  logic        pre_hc0;
  ent_t        wq[$];
  ent_t        rq[$];
  logic [18:0] hist [LAT+1];

  function automatic logic [35:0] mem(input logic [18:0] a);
    if (a == 19'h12345) return 36'hABCDE1234;
    return {a[16:0], a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected post-edge values from the inputs presented this cycle.
  task automatic model_pre();
    logic fs, fe, act;
    mst_t nx;
    pre_hc0 = hcount[0];
    if (reset) begin
      m_st = M_IDLE;
      e_we = 0; e_addr = 0; e_busy = 0; e_fd = 0;
      e_wc = 0; e_wd = 0; e_disp = 0;
      wq.delete();
      rq.delete();
      return;
    end
    fs  = (hcount == 11'd0) && (vcount == 10'd0);
    fe  = (hcount == 11'(HT - 1)) && (vcount == 10'(VT - 1));
    act = (hcount < 11'(HA)) && (vcount < 10'(VA));
    if ((m_st == M_ARMED || m_st == M_CAP) && fs) e_wc = 0;
    else if (e_we && e_wc != 19'h7FFFF) e_wc = e_wc + 19'd1;
    e_fd = (m_st == M_CAP) && fe;
    if (hcount[0]) begin
      e_addr = proc_pix_addr;
      e_we = (m_st == M_CAP) && act;
      if (e_we) wq.push_back('{cyc + 1 + LAT, two_proc_pixs});
    end else begin
      e_addr = disp_addr;
      e_we = 0;
      rq.push_back('{cyc + 2 + LAT, mem(disp_addr)});
    end
    nx = m_st;
    case (m_st)
      M_IDLE:  if (capture) nx = M_ARMED;
      M_ARMED: if (fs) nx = M_CAP;
      M_CAP:   if (fe && !continuous) nx = M_IDLE;
      default: nx = M_IDLE;
    endcase
    m_st = nx;
    e_busy = (nx != M_IDLE);
  endtask

  task automatic check();
    if (wq.size() > 0 && wq[0].due == cyc) begin
      e_wd = wq[0].val;
      void'(wq.pop_front());
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_disp = rq[0].val;
      void'(rq.pop_front());
    end
    chk("zbt_we", zbt_we, e_we);
    chk("zbt_addr", zbt_addr, e_addr);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_fd);
    chk("write_count", write_count, e_wc);
    chk("zbt_write_data", zbt_write_data, e_wd);
    chk("disp_pixs", disp_pixs, e_disp);
    if (zbt_we) begin
      we_seen++;
      chk("we_odd_slot", pre_hc0, 1);
    end
    if (frame_done) fd_seen++;
  endtask

  task automatic tick();
    model_pre();
    @(posedge clk);
    #1;
    cyc++;
    check();
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = zbt_addr;
    zbt_read_data = mem(hist[LAT]);
    if (hcount == 11'(HT - 1)) begin
      hcount = 0;
      vcount = (vcount == 10'(VT - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 11'd1;
    end
    two_proc_pixs = {4'hA, hcount, vcount, 11'(cyc)};
    proc_pix_addr = {vcount, hcount[9:1]};
    disp_addr = 19'($urandom);
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(hcount == 11'(h) && vcount == 10'(v)) && n < 2 * FR) begin
      tick();
      n++;
    end
    chk("wait_hv_reached", n < 2 * FR, 1);
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_seen < target && n < 3 * FR) begin
      tick();
      n++;
    end
    chk("wait_fd_reached", fd_seen >= target, 1);
  endtask

  task automatic pulse_capture();
    capture = 1;
    tick();
    capture = 0;
  endtask

  initial begin
    reset = 1; hcount = 0; vcount = 0;
    capture = 0; continuous = 0;
    two_proc_pixs = 0; proc_pix_addr = 0;
    disp_addr = 0; zbt_read_data = 0;
    for (int i = 0; i <= LAT; i++) hist[i] = '0;

    repeat (3) begin
      capture = 1'($urandom);
      continuous = 1'($urandom);
      two_proc_pixs = {4'h5, 32'($urandom)};
      tick();
    end
    reset = 0; capture = 0; continuous = 0;
    chk("rst_busy", busy, 0);
    chk("rst_wc", write_count, 0);
    chk("rst_wd", zbt_write_data, 0);

    we_seen = 0;
    repeat (FR) tick();
    chk("idle_no_we", we_seen, 0);

    // single capture armed mid-frame
    wait_hv(0, 2);
    pulse_capture();
    we_seen = 0; fd_seen = 0;
    wait_fd(1);
    chk("single_we", we_seen, (HA / 2) * VA);
    chk("single_wc", write_count, (HA / 2) * VA);
    chk("single_busy_fall", busy, 0);
    we_seen = 0;
    repeat (FR) tick();
    chk("after_single_no_we", we_seen, 0);

    // read path
    while (hcount[0]) tick();
    disp_addr = 19'h12345;
    repeat (4) tick();
    chk("rd_disp", disp_pixs, 36'hABCDE1234);
    tick();
    chk("rd_disp_hold", disp_pixs, 36'hABCDE1234);

    // continuous for three frames, dropped during the third
    wait_hv(0, 3);
    continuous = 1;
    pulse_capture();
    we_seen = 0; fd_seen = 0;
    wait_fd(2);
    chk("cont_busy", busy, 1);
    wait_hv(0, 2);
    continuous = 0;
    wait_fd(3);
    chk("cont_idle", busy, 0);
    repeat (FR) tick();
    chk("cont_fd", fd_seen, 3);
    chk("cont_we", we_seen, 3 * (HA / 2) * VA);

    // reset mid-capture
    pulse_capture();
    wait_hv(5, 2);
    chk("mid_in_capture", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_we", zbt_we, 0);
    chk("mid_rst_wc", write_count, 0);
    pulse_capture();
    we_seen = 0; fd_seen = 0;
    wait_fd(1);
    chk("rearm_we", we_seen, (HA / 2) * VA);

    // capture exactly on the frame-start cycle
    wait_hv(0, 0);
    pulse_capture();
    we_seen = 0; fd_seen = 0;
    repeat (FR - 1) tick();
    chk("fs_wait_no_we", we_seen, 0);
    chk("fs_armed_busy", busy, 1);

    // capture on the frame-end cycle is not re-armed
    wait_hv(HT - 1, VT - 1);
    capture = 1;
    tick();
    capture = 0;
    chk("fe_done", frame_done, 1);
    chk("fe_idle", busy, 0);
    chk("fe_we", we_seen, (HA / 2) * VA);
    we_seen = 0;
    repeat (2 * FR) tick();
    chk("fe_no_rearm", we_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
